wptr_full_ctrl: RTL and testbench
=================================

# wptr_full_ctrl

Write-domain pointer and status controller for the asynchronous FIFO, the next generation of the Gray-pointer write/full block. It holds the binary and Gray write pointers, produces the memory write address, and registers full, programmable almost-full, a write-side fill level and an optional sticky overflow flag. It sits in the `wclk` domain, between the FIFO write client, the dual-port memory, and the 2-flop synchroniser that delivers the read pointer as `wq2_rptr`.

## Interface
- `ADDRSIZE`, default 4: address width; depth DEPTH = 2^ADDRSIZE; legal range ≥ 2.
- `wclk` in 1: write clock.
- `wrst_n` in 1: reset, asynchronous, active-low; clock `wclk`.
- `winc` in 1: write request; accepted only when `wfull` = 0.
- `wq2_rptr` in ADDRSIZE+1: read pointer in Gray code, already synchronised into `wclk`.
- `wafull_thresh` in ADDRSIZE+1: almost-full threshold in words; quasi-static.
- `wovf_clr` in 1: clears the sticky overflow flag.
- `waddr` out ADDRSIZE: memory write address, equal to `wbin[ADDRSIZE-1:0]`.
- `wptr` out ADDRSIZE+1: registered Gray write pointer, sent to the read-domain synchroniser.
- `wfull` out 1: registered full flag.
- `wafull` out 1: registered almost-full flag.
- `wlevel` out ADDRSIZE+1: registered fill level as seen from the write side, range 0..DEPTH.
- `wovf` out 1: sticky overflow flag.

## Operation
- State registers: `wbin` and `wptr` (each ADDRSIZE+1 bits), plus `wfull`, `wafull`, `wlevel`, `wovf`.
- Write enable: `wen = winc & ~wfull`.
- Next binary pointer: `wbinnext = wbin + wen`, modulo 2^(ADDRSIZE+1).
- Next Gray pointer: `wgraynext = (wbinnext >> 1) ^ wbinnext`.
- Read-pointer decode: `rbin_s` is the Gray-to-binary conversion of `wq2_rptr`, computed as a combinational XOR-prefix from the MSB down.
- Next level: `levelnext = wbinnext - rbin_s`, modulo 2^(ADDRSIZE+1). With legal pointers this is always in 0..DEPTH.
- Full:
  - `wfull_val` is asserted when `wgraynext` equals `wq2_rptr` with its top two bits inverted.
  - The implementation must also guarantee `wfull_val == (levelnext == DEPTH)`.
- Almost-full: `wafull_val = (levelnext >= wafull_thresh)`.
  - Threshold 0 forces `wafull` high after the first clock.
  - Threshold > DEPTH means `wafull` never asserts.
- Each clock edge registers: `wbin <= wbinnext`, `wptr <= wgraynext`, `wfull <= wfull_val`, `wafull <= wafull_val`, `wlevel <= levelnext`.
- A write attempted while full is dropped: pointers, address and level are unchanged.
- Overflow (only when the configuration macro is defined):
  - `wovf` is set on any edge where `winc & wfull`.
  - `wovf` is cleared on an edge where `wovf_clr` = 1 and no new overflow occurs.
  - If set and clear happen on the same edge, set wins.
- Pointer wrap: `wbin` and the binary form of `wptr` wrap from 2^(ADDRSIZE+1)-1 to 0 with no special handling. The level and full computations stay correct because of the modular arithmetic.
- Reset, asynchronous and effective mid-operation: `wbin`, `wptr`, `waddr`, `wfull`, `wafull`, `wlevel` and `wovf` all go to 0 immediately. They stay 0 until the first `wclk` edge after `wrst_n` deasserts.

## Timing
- Every output is registered in `wclk`, except `waddr`, which is a direct slice of the `wbin` register. No combinational path exists from any input to any output.
- Write latency:
  - An accepted write on edge N updates `waddr`, `wptr` and `wlevel` immediately after edge N.
  - `wfull` and `wafull` after edge N already include that write, so there is no extra cycle of full latency.
- The memory write for edge N uses the `waddr` value present before edge N.
- Reader progress is visible only through `wq2_rptr`, which is 2+ `wclk` cycles stale. `wfull`, `wafull` and `wlevel` are therefore pessimistic (too high), never optimistic.
- `wptr` changes by at most one Gray step per edge, so exactly one bit toggles. This property is required for CDC safety.
- `wafull_thresh` may change only while `winc` = 0. `wafull` reflects the new value one edge later.

## Configuration
- `WPTR_OVERFLOW_FLAG_EN` defined: the sticky `wovf` register and `wovf_clr` logic are built as described above.
- Not defined: `wovf` is tied to constant 0, `wovf_clr` is ignored, and no overflow register is synthesised. All other behaviour is identical.

## Test plan
All scenarios use ADDRSIZE = 4, DEPTH = 16.

- **Reset:** pulse `wrst_n` low mid-clock.
  - All outputs are 0 asynchronously, before the next `wclk` edge.
  - First edge after release with `winc` = 0: all outputs stay 0.
- **Fill to full:** `wq2_rptr` = 0, `wafull_thresh` = 12, 16 back-to-back writes.
  - `wafull` rises after the 12th edge.
  - After the 16th edge: `wfull` = 1, `wlevel` = 16, `waddr` = 0, `wptr` = 5'b11000.
- **Overflow (macro defined):** 17th write while full.
  - `wptr` and `wlevel` unchanged, `wovf` = 1.
  - Pulse `wovf_clr` with `winc` = 0: `wovf` = 0 next edge.
  - `winc` and `wovf_clr` together while full: `wovf` stays 1.
- **Drain seen:** from full, set `wq2_rptr` = 5'b00001 (binary 1).
  - Next edge: `wfull` = 0, `wlevel` = 15, `wafull` = 1.
- **Wrap-around:** 40 writes with `wq2_rptr` trailing the write count by 4 words.
  - Final `wptr` = 5'b01100 (binary 8), `waddr` = 8, `wlevel` = 4, `wfull` = 0.
  - `wptr` toggles exactly one bit per accepted write throughout.
- **Reset mid-operation:** assert `wrst_n` low at level 10 while `winc` = 1.
  - All outputs 0 at once.
  - After release, the first write gives `waddr` = 1, `wlevel` = 1.

Source files
------------

// File: rtl/wptr_full_ctrl.sv
// -----------------------------------------------------------------------------
// wptr_full_ctrl
//
// Write-domain pointer and status controller for an asynchronous FIFO.
// Holds the binary and Gray write pointers, drives the memory write address,
// and registers full, programmable almost-full, the write-side fill level and
// an optional sticky overflow flag. Everything here lives in the wclk domain.
//
// Build option:
//   WPTR_OVERFLOW_FLAG_EN  defined   -> sticky wovf register with wovf_clr
//                          undefined -> wovf tied to 0, wovf_clr ignored
//
// Ports:
//   wclk           write clock
//   wrst_n         asynchronous active-low reset
//   winc           write request, accepted only while wfull = 0
//   wq2_rptr       Gray read pointer, already synchronised into wclk
//   wafull_thresh  almost-full threshold in words (quasi-static)
//   wovf_clr       clears the sticky overflow flag
//   waddr          memory write address (low bits of the binary pointer)
//   wptr           registered Gray write pointer, to the read-side synchroniser
//   wfull          registered full flag
//   wafull         registered almost-full flag (level >= wafull_thresh)
//   wlevel         registered write-side fill level, 0..2^ADDRSIZE
//   wovf           sticky overflow flag
// -----------------------------------------------------------------------------
module wptr_full_ctrl #(
    parameter int ADDRSIZE = 4
) (
    input  logic                wclk,
    input  logic                wrst_n,
    input  logic                winc,
    input  logic [ADDRSIZE:0]   wq2_rptr,
    input  logic [ADDRSIZE:0]   wafull_thresh,
    input  logic                wovf_clr,
    output logic [ADDRSIZE-1:0] waddr,
    output logic [ADDRSIZE:0]   wptr,
    output logic                wfull,
    output logic                wafull,
    output logic [ADDRSIZE:0]   wlevel,
    output logic                wovf
);

    // Gray to binary: each binary bit is the XOR of all Gray bits at or
    // above it, accumulated from the MSB down.
    function automatic logic [ADDRSIZE:0] gray2bin(input logic [ADDRSIZE:0] g);
        logic [ADDRSIZE:0] b;
        b[ADDRSIZE] = g[ADDRSIZE];
        for (int i = ADDRSIZE - 1; i >= 0; i--) begin
            b[i] = b[i+1] ^ g[i];
        end
        return b;
    endfunction

    logic [ADDRSIZE:0] wbin;
    logic [ADDRSIZE:0] wbinnext;
    logic [ADDRSIZE:0] wgraynext;
    logic [ADDRSIZE:0] rbin_s;
    logic [ADDRSIZE:0] levelnext;
    logic              wen;
    logic              wfull_val;
    logic              wafull_val;

    assign wen       = winc & ~wfull;
    assign wbinnext  = wbin + {{ADDRSIZE{1'b0}}, wen};
    assign wgraynext = (wbinnext >> 1) ^ wbinnext;
    assign rbin_s    = gray2bin(wq2_rptr);

    // Modular subtraction keeps the level correct across pointer wrap.
    assign levelnext = wbinnext - rbin_s;

    // Full when the next write pointer has lapped the read pointer exactly
    // once: in Gray code that is the read pointer with its top two bits
    // inverted. For legal pointers this coincides with levelnext == DEPTH.
    assign wfull_val  = (wgraynext == {~wq2_rptr[ADDRSIZE:ADDRSIZE-1],
                                        wq2_rptr[ADDRSIZE-2:0]});
    assign wafull_val = (levelnext >= wafull_thresh);

    assign waddr = wbin[ADDRSIZE-1:0];

    // Flags are computed from the post-write pointer, so they already include
    // the write accepted on this edge.
    always_ff @(posedge wclk or negedge wrst_n) begin
        if (!wrst_n) begin
            wbin   <= '0;
            wptr   <= '0;
            wfull  <= 1'b0;
            wafull <= 1'b0;
            wlevel <= '0;
        end else begin
            // NOTE: non-blocking assignments so every register samples the
            // pre-edge values; blocking here would chain updates in one cycle.
            wbin   <= wbinnext;
            wptr   <= wgraynext;
            wfull  <= wfull_val;
            wafull <= wafull_val;
            wlevel <= levelnext;
        end
    end

`ifdef WPTR_OVERFLOW_FLAG_EN
    // Set has priority over clear so an overflow coinciding with a clear
    // is never lost.
    always_ff @(posedge wclk or negedge wrst_n) begin
        if (!wrst_n) begin
            wovf <= 1'b0;
        end else if (winc && wfull) begin
            wovf <= 1'b1;
        end else if (wovf_clr) begin
            wovf <= 1'b0;
        end
    end
`else
    logic unused_wovf_clr;
    assign unused_wovf_clr = wovf_clr;
    assign wovf            = 1'b0;
`endif

endmodule

// File: tb/tb_wptr_full_ctrl.sv
// -----------------------------------------------------------------------------
// tb_wptr_full_ctrl
//
// Directed, self-checking bench for wptr_full_ctrl with ADDRSIZE = 4.
// Each scenario task drives stimulus and compares outputs against
// hand-computed values; overflow expectations follow WPTR_OVERFLOW_FLAG_EN.
// -----------------------------------------------------------------------------
module tb_wptr_full_ctrl;

    localparam int ADDRSIZE = 4;

    logic                wclk;
    logic                wrst_n;
    logic                winc;
    logic [ADDRSIZE:0]   wq2_rptr;
    logic [ADDRSIZE:0]   wafull_thresh;
    logic                wovf_clr;
    logic [ADDRSIZE-1:0] waddr;
    logic [ADDRSIZE:0]   wptr;
    logic                wfull;
    logic                wafull;
    logic [ADDRSIZE:0]   wlevel;
    logic                wovf;

    int n_chk;
    int n_pass;

`ifdef WPTR_OVERFLOW_FLAG_EN
    localparam logic OVF_ON = 1'b1;
`else
    localparam logic OVF_ON = 1'b0;
`endif

    wptr_full_ctrl #(.ADDRSIZE(ADDRSIZE)) dut (
        .wclk          (wclk),
        .wrst_n        (wrst_n),
        .winc          (winc),
        .wq2_rptr      (wq2_rptr),
        .wafull_thresh (wafull_thresh),
        .wovf_clr      (wovf_clr),
        .waddr         (waddr),
        .wptr          (wptr),
        .wfull         (wfull),
        .wafull        (wafull),
        .wlevel        (wlevel),
        .wovf          (wovf)
    );

    initial wclk = 1'b0;
    always #5 wclk = ~wclk;

    function automatic logic [ADDRSIZE:0] to_gray(input logic [ADDRSIZE:0] b);
        return b ^ (b >> 1);
    endfunction

    // Advance one edge and settle; inputs are changed and outputs sampled
    // 1 time unit after the rising edge.
    task automatic tick();
        @(posedge wclk);
        #1;
    endtask

    task automatic apply_reset();
        winc = 1'b0;
        wovf_clr = 1'b0;
        #2 wrst_n = 1'b0;
        #2 wrst_n = 1'b1;
        tick();
    endtask

    task automatic test_reset();
        logic [17:0] outs;
        wrst_n = 1'b1; winc = 1'b0; wovf_clr = 1'b0;
        wq2_rptr = '0; wafull_thresh = 5'd12;
        #3 wrst_n = 1'b0;
        #1;
        outs = {waddr, wptr, wfull, wafull, wlevel, wovf};
        n_chk++;
        if (outs !== 18'd0) $display("FAIL reset_async got %h exp 0", outs); else n_pass++;
        #2 wrst_n = 1'b1;
        tick();
        outs = {waddr, wptr, wfull, wafull, wlevel, wovf};
        n_chk++;
        if (outs !== 18'd0) $display("FAIL reset_first_edge got %h exp 0", outs); else n_pass++;
    endtask

    task automatic test_fill_to_full();
        wq2_rptr = '0; wafull_thresh = 5'd12; winc = 1'b1;
        for (int k = 1; k <= 16; k++) begin
            tick();
            n_chk++;
            if (wafull !== (k >= 12)) $display("FAIL fill_wafull edge %0d got %b exp %b", k, wafull, (k >= 12));
            else n_pass++;
            n_chk++;
            if (wlevel !== 5'(k)) $display("FAIL fill_level edge %0d got %0d exp %0d", k, wlevel, k);
            else n_pass++;
            if (k == 15) begin
                n_chk++;
                if (wfull !== 1'b0) $display("FAIL fill_not_full_15 got %b exp 0", wfull); else n_pass++;
            end
        end
        winc = 1'b0;
        n_chk++;
        if (wfull !== 1'b1) $display("FAIL full_flag got %b exp 1", wfull); else n_pass++;
        n_chk++;
        if (waddr !== 4'd0) $display("FAIL full_waddr got %0d exp 0", waddr); else n_pass++;
        n_chk++;
        if (wptr !== 5'b11000) $display("FAIL full_wptr got %b exp 11000", wptr); else n_pass++;
    endtask

    task automatic test_overflow();
        winc = 1'b1;
        tick();
        winc = 1'b0;
        n_chk++;
        if (wptr !== 5'b11000) $display("FAIL ovf_wptr got %b exp 11000", wptr); else n_pass++;
        n_chk++;
        if (wlevel !== 5'd16) $display("FAIL ovf_level got %0d exp 16", wlevel); else n_pass++;
        n_chk++;
        if (waddr !== 4'd0) $display("FAIL ovf_waddr got %0d exp 0", waddr); else n_pass++;
        n_chk++;
        if (wovf !== OVF_ON) $display("FAIL ovf_set got %b exp %b", wovf, OVF_ON); else n_pass++;
        wovf_clr = 1'b1;
        tick();
        wovf_clr = 1'b0;
        n_chk++;
        if (wovf !== 1'b0) $display("FAIL ovf_clear got %b exp 0", wovf); else n_pass++;
        winc = 1'b1; wovf_clr = 1'b1;
        tick();
        winc = 1'b0; wovf_clr = 1'b0;
        n_chk++;
        if (wovf !== OVF_ON) $display("FAIL ovf_set_beats_clr got %b exp %b", wovf, OVF_ON); else n_pass++;
        n_chk++;
        if (wfull !== 1'b1) $display("FAIL ovf_still_full got %b exp 1", wfull); else n_pass++;
    endtask

    task automatic test_drain_seen();
        wq2_rptr = 5'b00001;
        tick();
        n_chk++;
        if (wfull !== 1'b0) $display("FAIL drain_full got %b exp 0", wfull); else n_pass++;
        n_chk++;
        if (wlevel !== 5'd15) $display("FAIL drain_level got %0d exp 15", wlevel); else n_pass++;
        n_chk++;
        if (wafull !== 1'b1) $display("FAIL drain_wafull got %b exp 1", wafull); else n_pass++;
    endtask

    task automatic test_wrap_around();
        logic [ADDRSIZE:0] prev;
        logic [ADDRSIZE:0] diff;
        wq2_rptr = '0; wafull_thresh = 5'd12;
        apply_reset();
        for (int i = 1; i <= 40; i++) begin
            prev = wptr;
            wq2_rptr = (i >= 4) ? to_gray(5'(i - 4)) : 5'd0;
            winc = 1'b1;
            tick();
            diff = prev ^ wptr;
            n_chk++;
            if ($countones(diff) != 1) $display("FAIL wrap_one_bit write %0d prev %b now %b", i, prev, wptr);
            else n_pass++;
            n_chk++;
            if (wlevel !== ((i < 4) ? 5'(i) : 5'd4))
                $display("FAIL wrap_level write %0d got %0d exp %0d", i, wlevel, (i < 4) ? i : 4);
            else n_pass++;
            n_chk++;
            if (waddr !== 4'(i % 16)) $display("FAIL wrap_waddr write %0d got %0d exp %0d", i, waddr, i % 16);
            else n_pass++;
        end
        winc = 1'b0;
        n_chk++;
        if (wptr !== 5'b01100) $display("FAIL wrap_final_wptr got %b exp 01100", wptr); else n_pass++;
        n_chk++;
        if (waddr !== 4'd8) $display("FAIL wrap_final_waddr got %0d exp 8", waddr); else n_pass++;
        n_chk++;
        if (wlevel !== 5'd4) $display("FAIL wrap_final_level got %0d exp 4", wlevel); else n_pass++;
        n_chk++;
        if (wfull !== 1'b0) $display("FAIL wrap_final_full got %b exp 0", wfull); else n_pass++;
    endtask

    task automatic test_reset_mid_op();
        logic [17:0] outs;
        wq2_rptr = '0; wafull_thresh = 5'd12;
        apply_reset();
        winc = 1'b1;
        for (int k = 0; k < 10; k++) tick();
        n_chk++;
        if (wlevel !== 5'd10) $display("FAIL midrst_pre_level got %0d exp 10", wlevel); else n_pass++;
        #1 wrst_n = 1'b0;
        #1;
        outs = {waddr, wptr, wfull, wafull, wlevel, wovf};
        n_chk++;
        if (outs !== 18'd0) $display("FAIL midrst_async got %h exp 0", outs); else n_pass++;
        #1 wrst_n = 1'b1;
        tick();
        winc = 1'b0;
        n_chk++;
        if (waddr !== 4'd1) $display("FAIL midrst_waddr got %0d exp 1", waddr); else n_pass++;
        n_chk++;
        if (wlevel !== 5'd1) $display("FAIL midrst_level got %0d exp 1", wlevel); else n_pass++;
        n_chk++;
        if (wptr !== 5'b00001) $display("FAIL midrst_wptr got %b exp 00001", wptr); else n_pass++;
    endtask

    task automatic test_thresh_edges();
        // Threshold 0: almost-full after the first clock even when empty.
        wq2_rptr = '0; wafull_thresh = 5'd0;
        apply_reset();
        n_chk++;
        if (wafull !== 1'b1) $display("FAIL thresh0_wafull got %b exp 1", wafull); else n_pass++;
        // Threshold above depth: never asserts, even when full.
        wafull_thresh = 5'd17;
        winc = 1'b1;
        for (int k = 0; k < 16; k++) tick();
        winc = 1'b0;
        n_chk++;
        if (wafull !== 1'b0) $display("FAIL thresh17_wafull got %b exp 0", wafull); else n_pass++;
        n_chk++;
        if (wfull !== 1'b1) $display("FAIL thresh17_full got %b exp 1", wfull); else n_pass++;
        // Threshold change with winc low takes effect one edge later.
        wafull_thresh = 5'd16;
        tick();
        n_chk++;
        if (wafull !== 1'b1) $display("FAIL thresh16_wafull got %b exp 1", wafull); else n_pass++;
    endtask

    initial begin
        n_chk  = 0;
        n_pass = 0;
        test_reset();
        test_fill_to_full();
        test_overflow();
        test_drain_seen();
        test_wrap_around();
        test_reset_mid_op();
        test_thresh_edges();
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
